// File: rtl/dual_stack_pkg.sv
// Shared definitions for the dual stack controller: command encodings and default sizing.
package dual_stack_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority only moves when both requesters contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // 0 = requester A holds priority, 1 = requester B
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                gnt_o  = prio_q ? 2'b10 : 2'b01;
                prio_d = ~prio_q;
            end
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/dual_stack_ctrl.sv
// Two stacks growing toward each other in one single-port storage, shared by
// two requesters through a round-robin arbiter. Responses follow grants by one cycle.
module dual_stack_ctrl
    import dual_stack_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [1:0]        a_op,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [1:0]        b_op,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rsp_valid,
    output logic              rsp_stack,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   count_a,
    output logic [ADDR_W:0]   count_b,
    output logic              full
);

    logic [1:0]        gnt;
    logic              granted;
    logic              sel_b;
    op_e               sel_op;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W:0]   sel_cnt;
    logic [ADDR_W-1:0] cnt_lo;

    logic [ADDR_W:0]   count_a_q, count_a_d;
    logic [ADDR_W:0]   count_b_q, count_b_d;
    logic              rsp_valid_q, rsp_stack_q, rsp_err_q, rsp_rd_q;
    logic              rsp_err_d, rsp_rd_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({b_valid, a_valid}),
        .gnt_o (gnt)
    );

    assign a_ready  = gnt[0] & rst_n;
    assign b_ready  = gnt[1] & rst_n;
    assign granted  = a_ready | b_ready;
    assign sel_b    = gnt[1];
    assign sel_op   = op_e'(sel_b ? b_op : a_op);
    assign sel_data = sel_b ? b_data : a_data;
    assign sel_cnt  = sel_b ? count_b_q : count_a_q;
    assign cnt_lo   = sel_cnt[ADDR_W-1:0];
    assign full     = ({1'b0, count_a_q} + {1'b0, count_b_q}) == (ADDR_W + 2)'(DEPTH);

    // B addresses wrap modulo DEPTH: ~cnt is DEPTH-1-cnt and 0-cnt is DEPTH-cnt
    always_comb begin
        count_a_d = count_a_q;
        count_b_d = count_b_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_err_d = 1'b0;
        rsp_rd_d  = 1'b0;
        if (granted) begin
            case (sel_op)
                OP_PUSH: begin
                    if (full) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_wdata = sel_data;
                        mem_addr  = sel_b ? ~cnt_lo : cnt_lo;
                        if (sel_b) count_b_d = count_b_q + (ADDR_W + 1)'(1);
                        else       count_a_d = count_a_q + (ADDR_W + 1)'(1);
                    end
                end
                OP_POP, OP_PEEK: begin
                    if (sel_cnt == '0) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_rd_d = 1'b1;
                        mem_addr = sel_b ? (ADDR_W'(0) - cnt_lo) : (cnt_lo - ADDR_W'(1));
                        if (sel_op == OP_POP) begin
                            if (sel_b) count_b_d = count_b_q - (ADDR_W + 1)'(1);
                            else       count_a_d = count_a_q - (ADDR_W + 1)'(1);
                        end
                    end
                end
                OP_CLEAR: begin
                    if (sel_b) count_b_d = '0;
                    else       count_a_d = '0;
                end
                default: rsp_err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_a_q   <= '0;
            count_b_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_stack_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            count_a_q   <= count_a_d;
            count_b_q   <= count_b_d;
            rsp_valid_q <= granted;
            rsp_stack_q <= sel_b;
            rsp_err_q   <= rsp_err_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    // A response still in flight when reset arrives is suppressed immediately
    assign rsp_valid = rsp_valid_q & rst_n;
    assign rsp_stack = rsp_stack_q;
    assign rsp_err   = rsp_err_q & rsp_valid;
    assign rsp_data  = (rsp_valid && rsp_rd_q) ? mem_rdata : '0;
    assign count_a   = count_a_q;
    assign count_b   = count_b_q;

endmodule

// File: tb/tb_dual_stack_ctrl.sv
// Scoreboard bench for dual_stack_ctrl: a queue-based stack model predicts grants,
// storage accesses and responses; a separate monitor checks responses as they appear.
module tb_dual_stack_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]        a_op = 2'b00, b_op = 2'b00;
    logic [DATA_W-1:0] a_data = '0, b_data = '0;
    logic              a_ready, b_ready;
    logic              rsp_valid, rsp_stack, rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [ADDR_W:0]   count_a, count_b;
    logic              full;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int                due;
        logic              stk;
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              expQ[$];
    logic [DATA_W-1:0] stkA[$];
    logic [DATA_W-1:0] stkB[$];
    logic              prio = 1'b0;
    logic [DATA_W-1:0] ram [DEPTH];

    dual_stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_op      (a_op),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_op      (b_op),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rsp_valid (rsp_valid),
        .rsp_stack (rsp_stack),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .count_a   (count_a),
        .count_b   (count_b),
        .full      (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port storage with one-cycle read latency, read-before-write
    initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [1:0] aop, input logic [7:0] ad,
                                 input logic bv, input logic [1:0] bop, input logic [7:0] bd);
        @(posedge clk);
        #1;
        a_valid = av; a_op = aop; a_data = ad;
        b_valid = bv; b_op = bop; b_data = bd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic cmdA(input logic [1:0] op, input logic [7:0] d);
        applyStimulus(1'b1, op, d, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic cmdB(input logic [1:0] op, input logic [7:0] d);
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b1, op, d);
    endtask

    // Reference model: predicts each cycle's grant and storage access from the
    // stack contents, then queues the response due on the following cycle.
    always @(negedge clk) begin : refModel
        int                g;
        int                sz;
        logic [1:0]        op;
        logic [DATA_W-1:0] d;
        logic              expWe;
        logic [ADDR_W-1:0] expAddr;
        exp_t              e;
        if (!rst_n) begin
            stkA.delete();
            stkB.delete();
            prio = 1'b0;
            checkOutput("ready_in_reset", {30'd0, a_ready, b_ready}, 32'd0);
            checkOutput("mem_we_in_reset", {31'd0, mem_we}, 32'd0);
        end else begin
            g = 0;
            if (a_valid && b_valid) begin
                g = prio ? 2 : 1;
                prio = ~prio;
            end else if (a_valid) g = 1;
            else if (b_valid) g = 2;
            checkOutput("a_ready", {31'd0, a_ready}, {31'd0, g == 1});
            checkOutput("b_ready", {31'd0, b_ready}, {31'd0, g == 2});
            checkOutput("count_a", {27'd0, count_a}, 32'(stkA.size()));
            checkOutput("count_b", {27'd0, count_b}, 32'(stkB.size()));
            checkOutput("full", {31'd0, full}, {31'd0, (stkA.size() + stkB.size()) == DEPTH});
            expWe = 1'b0; expAddr = '0; d = '0;
            if (g != 0) begin
                op = (g == 1) ? a_op : b_op;
                d  = (g == 1) ? a_data : b_data;
                sz = (g == 1) ? stkA.size() : stkB.size();
                e.due = cyc + 1; e.stk = (g == 2); e.err = 1'b0; e.data = '0;
                case (op)
                    2'b00: begin
                        if (stkA.size() + stkB.size() == DEPTH) e.err = 1'b1;
                        else begin
                            expWe = 1'b1;
                            expAddr = (g == 1) ? ADDR_W'(sz) : ADDR_W'(DEPTH - 1 - sz);
                            if (g == 1) stkA.push_back(d); else stkB.push_back(d);
                        end
                    end
                    2'b01, 2'b10: begin
                        if (sz == 0) e.err = 1'b1;
                        else begin
                            expAddr = (g == 1) ? ADDR_W'(sz - 1) : ADDR_W'(DEPTH - sz);
                            e.data = (g == 1) ? stkA[$] : stkB[$];
                            if (op == 2'b01) begin
                                if (g == 1) void'(stkA.pop_back()); else void'(stkB.pop_back());
                            end
                        end
                    end
                    default: begin
                        if (g == 1) stkA.delete(); else stkB.delete();
                    end
                endcase
                expQ.push_back(e);
            end
            checkOutput("mem_we", {31'd0, mem_we}, {31'd0, expWe});
            checkOutput("mem_addr", {28'd0, mem_addr}, {28'd0, expAddr});
            if (expWe) checkOutput("mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
        end
    end

    // Monitor: a response must appear exactly in the cycle it is due, and never in reset
    always @(negedge clk) begin : respMonitor
        exp_t e;
        logic expV;
        if (!rst_n) begin
            checkOutput("rsp_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
            while (expQ.size() > 0 && expQ[0].due <= cyc + 1) void'(expQ.pop_front());
        end else begin
            expV = (expQ.size() > 0) && (expQ[0].due == cyc);
            checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, expV});
            if (expV) begin
                e = expQ.pop_front();
                if (rsp_valid) begin
                    checkOutput("rsp_stack", {31'd0, rsp_stack}, {31'd0, e.stk});
                    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        int r;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        cmdA(2'b00, 8'h11); cmdA(2'b00, 8'h22);
        cmdA(2'b01, 8'h00); cmdA(2'b01, 8'h00);
        idle();

        cmdB(2'b00, 8'h5A); cmdB(2'b10, 8'h00);
        idle();

        cmdA(2'b01, 8'h00);
        cmdB(2'b00, 8'h6B); cmdB(2'b00, 8'h7C); cmdB(2'b11, 8'h00);
        idle();

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 2'b00, 8'(8'hA0 + i), 1'b1, 2'b00, 8'(8'hB0 + i));
        cmdA(2'b11, 8'h00); cmdB(2'b11, 8'h00);

        for (int i = 0; i < 10; i++) cmdA(2'b00, 8'(8'h30 + i));
        for (int i = 0; i < 6; i++)  cmdB(2'b00, 8'(8'h60 + i));
        cmdA(2'b00, 8'hEE); cmdB(2'b00, 8'hEF);
        cmdA(2'b01, 8'h00); cmdA(2'b00, 8'h77); cmdA(2'b01, 8'h00);
        cmdB(2'b10, 8'h00);

        cmdA(2'b01, 8'h00);
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();

        for (int i = 0; i < 400; i++) begin
            logic [1:0] opA, opB;
            r = $urandom_range(0, 19);
            opA = (r < 9) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 19);
            opB = (r < 9) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
            applyStimulus(1'($urandom_range(0, 1)), opA, 8'($urandom),
                          1'($urandom_range(0, 1)), opB, 8'($urandom));
        end

        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_stack_ctrl.md
DUAL_STACK_CTRL -- requirements
Module: dual_stack_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, word width; DEPTH, default 16, shared storage entries (power of two); ADDR_W, default log2(DEPTH), address width.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 a_valid / b_valid  input  1  requester A/B command valid.
REQ-005 a_op / b_op  input  2  command: 00 push, 01 pop, 10 peek, 11 clear.
REQ-006 a_data / b_data  input  DATA_W  push data.
REQ-007 a_ready / b_ready  output  1  command accepted this cycle (grant).
REQ-008 rsp_valid  output  1  one response per accepted command.
REQ-009 rsp_stack  output  1  0 = stack A, 1 = stack B.
REQ-010 rsp_err  output  1  command refused (overflow or underflow).
REQ-011 rsp_data  output  DATA_W  pop/peek data; 0 otherwise.
REQ-012 mem_we  output  1  storage write strobe.
REQ-013 mem_addr  output  ADDR_W  storage address.
REQ-014 mem_wdata  output  DATA_W  storage write data.
REQ-015 mem_rdata  input  DATA_W  storage read data, valid one cycle after the address.
REQ-016 count_a / count_b  output  ADDR_W+1  current stack depths.
REQ-017 full  output  1  count_a + count_b == DEPTH.

Function
REQ-018 Stack A SHALL occupy addresses upward from 0; stack B downward from DEPTH-1; both share one single-port storage.
REQ-019 At most one command SHALL be granted per cycle; a requester's ready SHALL be high only in a cycle when its valid is high and it wins arbitration.
REQ-020 Arbitration SHALL be round-robin: with a single valid, that requester wins; with both valid, the priority holder wins and priority passes to the other requester.
REQ-021 Push A (not full): mem_we=1, mem_addr=count_a, count_a+1; push B: mem_addr=DEPTH-1-count_b, count_b+1; all in the grant cycle.
REQ-022 Pop/peek A (count_a>0): mem_addr=count_a-1, mem_we=0; pop B: mem_addr=DEPTH-count_b; pop decrements the count in the grant cycle, peek leaves it unchanged.
REQ-023 Clear SHALL set the selected count to 0 with no storage access and SHALL never set rsp_err.
REQ-024 Push when full, or pop/peek when the selected count is 0, SHALL perform no storage access, SHALL leave the counts unchanged, and SHALL return rsp_err=1 with rsp_data=0.
REQ-025 A response SHALL be presented exactly one cycle after the grant, with rsp_stack equal to the granted requester; for a successful pop/peek, rsp_data SHALL equal mem_rdata in that cycle.
REQ-026 Responses SHALL NOT be back-pressured; sustained throughput SHALL be one command per cycle.
REQ-027 When no command is granted, mem_we SHALL be 0 and mem_addr SHALL hold 0.
REQ-028 Push-after-pop to the same address on consecutive cycles SHALL be legal; the pop response SHALL return the pre-write value.

Reset
REQ-029 With rst_n low at a clock edge: counts=0, priority=A, rsp_valid=0, rsp_err=0, rsp_data=0, mem_we=0, a_ready=b_ready=0.
REQ-030 A response pending at reset SHALL be discarded; storage contents SHALL NOT be cleared.

Structure
REQ-031 The package dual_stack_pkg SHALL hold the op encodings and the default DATA_W/DEPTH.
REQ-032 Arbitration SHALL be a sub-module rr_arb2 (2-way round-robin, one priority flop).

Verification
REQ-033 Reset, then push A 0x11, 0x22 and pop A twice -> responses 0x22 then 0x11, err=0, count_a=0.
REQ-034 Push B 0x5A -> mem_addr=15, mem_we=1; peek B -> rsp_data=0x5A, count_b stays 1.
REQ-035 Fill 10 on A and 6 on B -> full=1; push A -> rsp_err=1, no mem_we, counts unchanged.
REQ-036 Both valid for 4 cycles -> grants A,B,A,B and rsp_stack 0,1,0,1.
REQ-037 Pop A when empty -> rsp_err=1, rsp_data=0x00; clear B with count_b=3 -> count_b=0, err=0.
REQ-038 Assert rst_n=0 in the cycle after a pop grant -> no rsp_valid, counts 0.
